// File: rtl/mul_acc_pipe.sv
// Pipelined multiply / multiply-accumulate unit with valid/ready handshake on both sides.
// Operands register in stage 1, the product rides stages 2..STAGES-1, and the accumulator lives in the final stage.
module mul_acc_pipe #(
   parameter int A_WIDTH   = 18,
   parameter int B_WIDTH   = 18,
   parameter int ACC_WIDTH = 48,
   parameter int STAGES    = 2,
   parameter int SIGNED    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_WIDTH-1:0]   in_a,
   input  logic [B_WIDTH-1:0]   in_b,
   input  logic [1:0]           in_op,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic                 out_last,
   output logic                 out_ovf
);

   localparam int PW = A_WIDTH + B_WIDTH;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_ACC  = 2'b01,
      OP_SUB  = 2'b10,
      OP_LOAD = 2'b11
   } op_e;

   // Operands are widened to the full product width first, so the low PW bits are exact for either signedness.
   function automatic logic [PW-1:0] mul_fn(input logic [A_WIDTH-1:0] a, input logic [B_WIDTH-1:0] b);
      logic signed [PW-1:0] ax;
      logic signed [PW-1:0] bx;
      if (SIGNED != 0) begin
         ax = PW'($signed(a));
         bx = PW'($signed(b));
      end else begin
         ax = PW'(a);
         bx = PW'(b);
      end
      return PW'(ax * bx);
   endfunction

   function automatic logic [ACC_WIDTH-1:0] ext_fn(input logic [PW-1:0] p);
      if (SIGNED != 0) return ACC_WIDTH'($signed(p));
      else             return ACC_WIDTH'(p);
   endfunction

   // Returns {overflow, wrapped result}; overflow is signed overflow or carry/borrow depending on SIGNED.
   function automatic logic [ACC_WIDTH:0] addsub_fn(input logic [ACC_WIDTH-1:0] x,
                                                    input logic [ACC_WIDTH-1:0] y,
                                                    input logic             sub);
      logic [ACC_WIDTH:0] r;
      logic               ovf;
      r = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
      if (SIGNED != 0) begin
         if (sub) ovf = (x[ACC_WIDTH-1] != y[ACC_WIDTH-1]) && (r[ACC_WIDTH-1] != x[ACC_WIDTH-1]);
         else     ovf = (x[ACC_WIDTH-1] == y[ACC_WIDTH-1]) && (r[ACC_WIDTH-1] != x[ACC_WIDTH-1]);
      end else begin
         ovf = r[ACC_WIDTH];
      end
      return {ovf, r[ACC_WIDTH-1:0]};
   endfunction

   logic          adv;
   logic          fin_vld;
   logic [1:0]    fin_op;
   logic          fin_last;
   logic [PW-1:0] fin_prod;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   generate
      if (STAGES == 1) begin : g_direct
         assign fin_vld  = in_valid;
         assign fin_op   = in_op;
         assign fin_last = in_last;
         assign fin_prod = mul_fn(in_a, in_b);
      end else begin : g_pipe
         localparam int N = STAGES - 1;

         logic [N-1:0]               vld_p;
         logic [N-1:0]               last_p;
         logic [1:0]                 op_p [N];
         logic signed [A_WIDTH-1:0]  a_p1;
         logic signed [B_WIDTH-1:0]  b_p1;
         logic [PW-1:0]              prod_p1;

         // Stage 1: operand capture; control shifts alongside
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               vld_p <= '0;
            end else if (adv) begin
               vld_p[0] <= in_valid;
               for (int i = 1; i < N; i++) vld_p[i] <= vld_p[i-1];
            end
         end

         always_ff @(posedge clk) begin
            if (adv) begin
               a_p1      <= in_a;
               b_p1      <= in_b;
               op_p[0]   <= in_op;
               last_p[0] <= in_last;
               for (int i = 1; i < N; i++) begin
                  op_p[i]   <= op_p[i-1];
                  last_p[i] <= last_p[i-1];
               end
            end
         end

         assign prod_p1 = mul_fn(a_p1, b_p1);

         if (N == 1) begin : g_no_carry
            assign fin_prod = prod_p1;
         end else begin : g_carry
            logic [PW-1:0] prod_p [N-1];

            // Stages 2..STAGES-1: product carry registers
            always_ff @(posedge clk) begin
               if (adv) begin
                  prod_p[0] <= prod_p1;
                  for (int j = 1; j < N - 1; j++) prod_p[j] <= prod_p[j-1];
               end
            end

            assign fin_prod = prod_p[N-2];
         end

         assign fin_vld  = vld_p[N-1];
         assign fin_op   = op_p[N-1];
         assign fin_last = last_p[N-1];
      end
   endgenerate

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_nxt;
   logic [ACC_WIDTH-1:0]        prod_ext;
   logic [ACC_WIDTH-1:0]        res;
   logic [ACC_WIDTH:0]          sum_r;
   logic                        ovf_nxt;

   always_comb begin
      prod_ext = ext_fn(fin_prod);
      sum_r    = addsub_fn(acc, prod_ext, fin_op == OP_SUB);
      acc_nxt  = acc;
      res      = prod_ext;
      ovf_nxt  = 1'b0;
      case (fin_op)
         OP_ACC, OP_SUB: begin
            acc_nxt = sum_r[ACC_WIDTH-1:0];
            res     = sum_r[ACC_WIDTH-1:0];
            ovf_nxt = sum_r[ACC_WIDTH];
         end
         OP_LOAD: acc_nxt = prod_ext;
         default: ;
      endcase
   end

   // Final stage: accumulator and output register; bubbles leave everything but out_valid untouched
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         acc       <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_ovf   <= 1'b0;
      end else if (adv) begin
         out_valid <= fin_vld;
         if (fin_vld) begin
            acc      <= acc_nxt;
            out_data <= res;
            out_last <= fin_last;
            out_ovf  <= ovf_nxt;
         end
      end
   end

endmodule

// File: tb/tb_mul_acc_pipe.sv
// Directed bench for mul_acc_pipe: several parameterisations share one stimulus bus,
// each test checks the instance whose configuration it targets.
module tb_mul_acc_pipe;

   localparam logic [1:0] MUL = 2'b00, ACC = 2'b01, SUB = 2'b10, LOAD = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [17:0] in_a;
   logic [17:0] in_b;
   logic [1:0]  in_op;
   logic        in_last;
   logic        out_ready;

   logic rdy2, ov2, ol2, of2;  logic [47:0] od2;
   logic rdy3, ov3, ol3, of3;  logic [47:0] od3;
   logic rdy1, ov1, ol1, of1;  logic [47:0] od1;
   logic rdys, ovs, ols, ofs;  logic [35:0] ods;
   logic rdyu, ovu, olu, ofu;  logic [35:0] odu;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0] op;
      int         a;
      int         b;
      bit         last;
      longint     exp;
      bit         exp_last;
      bit         exp_ovf;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   mul_acc_pipe #(.STAGES(2)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
      .out_last(ol2), .out_ovf(of2));
   mul_acc_pipe #(.STAGES(3)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .in_last(in_last), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
      .out_last(ol3), .out_ovf(of3));
   mul_acc_pipe #(.STAGES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
      .out_last(ol1), .out_ovf(of1));
   mul_acc_pipe #(.ACC_WIDTH(36), .STAGES(2), .SIGNED(1)) us36 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdys), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .in_last(in_last), .out_valid(ovs), .out_ready(out_ready), .out_data(ods),
      .out_last(ols), .out_ovf(ofs));
   mul_acc_pipe #(.ACC_WIDTH(36), .STAGES(2), .SIGNED(0)) uu36 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyu), .in_a(in_a), .in_b(in_b),
      .in_op(in_op), .in_last(in_last), .out_valid(ovu), .out_ready(out_ready), .out_data(odu),
      .out_last(olu), .out_ovf(ofu));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [1:0] op, input int a, input int b, input bit last,
                               input longint exp, input bit exp_last, input bit exp_ovf);
      vecs.push_back('{op, a, b, last, exp, exp_last, exp_ovf});
   endfunction

   task automatic do_reset(input int n);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = MUL;
      in_a      = '0;
      in_b      = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drive(input logic [1:0] op, input int a, input int b, input bit last);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = 18'(a);
      in_b     = 18'(b);
      in_last  = last;
   endtask

   // Streams vecs back-to-back into a STAGES=2 instance; each result appears one edge after acceptance.
   task automatic run_vecs(input int sel, input string tag);
      logic [63:0] mask;
      mask = (sel == 0) ? 64'hFFFF_FFFF_FFFF : 64'hF_FFFF_FFFF;
      for (int i = 0; i <= vecs.size(); i++) begin
         if (i < vecs.size()) drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].last);
         else in_valid = 1'b0;
         @(posedge clk);
         #1;
         if (i > 0) begin
            logic        v, l, o;
            logic [63:0] d;
            case (sel)
               0:       begin v = ov2; l = ol2; o = of2; d = 64'(od2); end
               1:       begin v = ovs; l = ols; o = ofs; d = 64'(ods); end
               default: begin v = ovu; l = olu; o = ofu; d = 64'(odu); end
            endcase
            chk($sformatf("%s[%0d].valid", tag, i-1), 64'(v), 64'd1);
            chk($sformatf("%s[%0d].data", tag, i-1), d, 64'(vecs[i-1].exp) & mask);
            chk($sformatf("%s[%0d].last", tag, i-1), 64'(l), 64'(vecs[i-1].exp_last));
            chk($sformatf("%s[%0d].ovf", tag, i-1), 64'(o), 64'(vecs[i-1].exp_ovf));
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int sent;
      int got;
      logic [47:0] last_xfer;

      // Reset and idle
      do_reset(3);
      chk("rst.out_valid", 64'(ov2), 64'd0);
      chk("rst.out_data", 64'(od2), 64'd0);
      chk("rst.out_last", 64'(ol2), 64'd0);
      chk("rst.out_ovf", 64'(of2), 64'd0);
      chk("rst.in_ready", 64'(rdy2), 64'd1);

      // Signed 48-bit table on STAGES=2
      vecs.delete();
      add(MUL,  -3, 7, 0, -21, 0, 0);
      add(ACC,  1, 1, 0, 1, 0, 0);
      add(LOAD, 2, 5, 0, 10, 0, 0);
      add(ACC,  3, 4, 0, 22, 0, 0);
      add(SUB,  1, 6, 1, 16, 1, 0);
      add(MUL,  100, -100, 0, -10000, 0, 0);
      add(ACC,  -2, 3, 0, 10, 0, 0);
      add(SUB,  -4, -5, 0, -10, 0, 0);
      add(LOAD, 131071, 131071, 0, 64'd17179607041, 0, 0);
      add(MUL,  -131072, -131072, 0, 64'd17179869184, 0, 0);
      add(ACC,  -131072, 131071, 0, -131071, 0, 0);
      add(ACC,  0, 0, 1, -131071, 1, 0);
      run_vecs(0, "s48");

      // Signed 36-bit overflow table
      do_reset(1);
      vecs.delete();
      add(LOAD, -131072, -131072, 0, 64'h4_0000_0000, 0, 0);
      add(ACC,  -131072, -131072, 0, 64'h8_0000_0000, 0, 1);
      add(ACC,  0, 0, 0, 64'h8_0000_0000, 0, 0);
      add(SUB,  -131072, -131072, 0, 64'h4_0000_0000, 0, 1);
      add(SUB,  -131072, 131071, 0, 64'd34359607296, 0, 0);
      add(MUL,  3, 3, 0, 9, 0, 0);
      add(ACC,  1, 1, 1, 64'd34359607297, 1, 0);
      run_vecs(1, "s36");

      // Unsigned 36-bit carry/borrow table
      do_reset(1);
      vecs.delete();
      add(LOAD, 262143, 262143, 0, 64'hF_FFF8_0001, 0, 0);
      add(ACC,  262143, 262143, 0, 64'hF_FFF0_0002, 0, 1);
      add(SUB,  1, 1, 0, 64'hF_FFF0_0001, 0, 0);
      add(LOAD, 0, 0, 0, 0, 0, 0);
      add(SUB,  1, 1, 0, 64'hF_FFFF_FFFF, 0, 1);
      add(ACC,  1, 1, 0, 0, 0, 1);
      add(MUL,  262143, 262143, 1, 64'hF_FFF8_0001, 1, 0);
      run_vecs(2, "u36");

      // Accumulate group on STAGES=3: three beats accepted at edges k..k+2
      do_reset(1);
      drive(LOAD, 2, 5, 0);
      @(posedge clk); #1;
      drive(ACC, 3, 4, 0);
      @(posedge clk); #1;
      chk("grp.latency_valid", 64'(ov3), 64'd0);
      drive(SUB, 1, 6, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("grp0.valid", 64'(ov3), 64'd1);
      chk("grp0.data", 64'(od3), 64'd10);
      chk("grp0.last", 64'(ol3), 64'd0);
      @(posedge clk); #1;
      chk("grp1.valid", 64'(ov3), 64'd1);
      chk("grp1.data", 64'(od3), 64'd22);
      chk("grp1.last", 64'(ol3), 64'd0);
      @(posedge clk); #1;
      chk("grp2.valid", 64'(ov3), 64'd1);
      chk("grp2.data", 64'(od3), 64'd16);
      chk("grp2.last", 64'(ol3), 64'd1);
      @(posedge clk); #1;
      chk("grp.drain_valid", 64'(ov3), 64'd0);
      chk("grp.drain_data", 64'(od3), 64'd16);

      // Backpressure: six ACC 1x1 beats with out_ready low for cycles 4..7
      do_reset(1);
      sent = 0;
      got  = 0;
      last_xfer = '0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         logic acc_now, xfer_now;
         out_ready = !(c >= 4 && c < 8);
         if (sent < 6) drive(ACC, 1, 1, 0);
         else in_valid = 1'b0;
         #1;
         if (ov2) chk($sformatf("bp.c%0d.data", c), 64'(od2), 64'(got + 1));
         if (ov2 && !out_ready) chk($sformatf("bp.c%0d.in_ready", c), 64'(rdy2), 64'd0);
         acc_now  = in_valid && rdy2;
         xfer_now = ov2 && out_ready;
         if (xfer_now) last_xfer = od2;
         @(posedge clk); #1;
         if (acc_now) sent++;
         if (xfer_now) got++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp.sent", 64'(sent), 64'd6);
      chk("bp.got", 64'(got), 64'd6);
      chk("bp.final", 64'(last_xfer), 64'd6);
      repeat (2) begin
         @(posedge clk); #1;
         chk("bp.no_extra", 64'(ov2), 64'd0);
      end

      // Reset with two beats in flight in the STAGES=3 unit
      do_reset(1);
      drive(LOAD, 5, 5, 0);
      @(posedge clk); #1;
      drive(ACC, 7, 7, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid.valid", 64'(ov3), 64'd0);
      chk("mid.data", 64'(od3), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("mid.flushed%0d", i), 64'(ov3), 64'd0);
      end
      drive(ACC, 4, 4, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("s1.valid", 64'(ov1), 64'd1);
      chk("s1.data", 64'(od1), 64'd16);
      @(posedge clk);
      @(posedge clk); #1;
      chk("mid.after.valid", 64'(ov3), 64'd1);
      chk("mid.after.data", 64'(od3), 64'd16);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
